// File: rtl/i2c_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : i2c_slave
//  Description : I2C responder with a 7-bit address. SCL and SDA are
//                oversampled on clk. Received write bytes are presented on
//                rx_data. Read bytes are fetched from tx_data. SDA is
//                open-drain: it is only ever driven low or released.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic       tx_rd,
    output logic [7:0] rx_data,
    output logic       rx_wr,
    output logic       rw,
    output logic       busy,
    output logic       i2c_done
);

    // Protocol states
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADDR     = 3'd1;
    localparam logic [2:0] S_ADDR_ACK = 3'd2;
    localparam logic [2:0] S_WR_DATA  = 3'd3;
    localparam logic [2:0] S_WR_ACK   = 3'd4;
    localparam logic [2:0] S_RD_DATA  = 3'd5;
    localparam logic [2:0] S_RD_ACK   = 3'd6;

    // Synchronizer chains plus one-clk-delayed copies for edge detection
    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;

    // Protocol state
    logic [2:0] state_q,   state_d;
    logic [2:0] bitcnt_q,  bitcnt_d;
    logic [6:0] shift_q,   shift_d;
    logic       ack_ph_q,  ack_ph_d;
    logic       sda_oe_q,  sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rw_q,      rw_d;
    logic       busy_q,    busy_d;
    logic       tx_rd_q,   tx_rd_d;
    logic       rx_wr_q,   rx_wr_d;
    logic       done_q,    done_d;

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    // Bring the asynchronous bus lines into the clk domain; idle bus reads high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_meta_q <= scl;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= sda;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
        end
    end

    assign scl_rise  =  scl_sync_q & ~scl_prev_q;
    assign scl_fall  = ~scl_sync_q &  scl_prev_q;
    // START/STOP are SDA transitions while SCL is stably high
    assign start_det =  scl_sync_q &  scl_prev_q &  sda_prev_q & ~sda_sync_q;
    assign stop_det  =  scl_sync_q &  scl_prev_q & ~sda_prev_q &  sda_sync_q;

    // Next-state logic for the protocol engine
    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        ack_ph_d  = ack_ph_q;
        sda_oe_d  = sda_oe_q;
        rx_data_d = rx_data_q;
        rw_d      = rw_q;
        busy_d    = busy_q;
        tx_rd_d   = 1'b0;
        rx_wr_d   = 1'b0;
        done_d    = 1'b0;

        if (stop_det) begin
            state_d  = S_IDLE;
            bitcnt_d = 3'd0;
            ack_ph_d = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = busy_q;
        end else if (start_det) begin
            // Also covers repeated START: restart address reception
            state_d  = S_ADDR;
            bitcnt_d = 3'd0;
            ack_ph_d = 1'b0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d  = {shift_q[5:0], sda_sync_q};
                        bitcnt_d = 3'(bitcnt_q + 3'd1);
                        if (bitcnt_q == 3'd7) begin
                            // shift_q holds address bits [7:1], sda is R/W
                            if (shift_q == SLAVE_ADDR) begin
                                rw_d     = sda_sync_q;
                                busy_d   = 1'b1;
                                ack_ph_d = 1'b0;
                                state_d  = S_ADDR_ACK;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = S_IDLE;
                            end
                        end
                    end
                end

                S_ADDR_ACK, S_WR_ACK: begin
                    // First falling edge starts the ACK low, second ends it
                    if (scl_fall) begin
                        if (!ack_ph_q) begin
                            ack_ph_d = 1'b1;
                            sda_oe_d = 1'b1;
                        end else begin
                            ack_ph_d = 1'b0;
                            bitcnt_d = 3'd0;
                            if ((state_q == S_ADDR_ACK) && rw_q) begin
                                shift_d  = tx_data[6:0];
                                tx_rd_d  = 1'b1;
                                sda_oe_d = ~tx_data[7];
                                state_d  = S_RD_DATA;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = S_WR_DATA;
                            end
                        end
                    end
                end

                S_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d  = {shift_q[5:0], sda_sync_q};
                        bitcnt_d = 3'(bitcnt_q + 3'd1);
                        if (bitcnt_q == 3'd7) begin
                            rx_data_d = {shift_q, sda_sync_q};
                            rx_wr_d   = 1'b1;
                            ack_ph_d  = 1'b0;
                            state_d   = S_WR_ACK;
                        end
                    end
                end

                S_RD_DATA: begin
                    if (scl_rise) begin
                        bitcnt_d = 3'(bitcnt_q + 3'd1);
                        if (bitcnt_q == 3'd7) begin
                            ack_ph_d = 1'b0;
                            state_d  = S_RD_ACK;
                        end
                    end else if (scl_fall) begin
                        // A 1 bit is sent by releasing the line
                        sda_oe_d = ~shift_q[6];
                        shift_d  = {shift_q[5:0], 1'b0};
                    end
                end

                S_RD_ACK: begin
                    if (scl_fall) begin
                        if (ack_ph_q) begin
                            // Initiator ACKed: fetch and present the next byte
                            ack_ph_d = 1'b0;
                            bitcnt_d = 3'd0;
                            shift_d  = tx_data[6:0];
                            tx_rd_d  = 1'b1;
                            sda_oe_d = ~tx_data[7];
                            state_d  = S_RD_DATA;
                        end else begin
                            sda_oe_d = 1'b0;
                        end
                    end else if (scl_rise) begin
                        if (!sda_sync_q) begin
                            ack_ph_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            busy_d   = 1'b0;
                            state_d  = S_IDLE;
                        end
                    end
                end

                default: begin
                    // IDLE: bus activity is ignored until the next START
                    state_d  = S_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State registers; reset also releases SDA without waiting for a clock
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            bitcnt_q  <= 3'd0;
            shift_q   <= 7'd0;
            ack_ph_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
            rx_data_q <= 8'd0;
            rw_q      <= 1'b0;
            busy_q    <= 1'b0;
            tx_rd_q   <= 1'b0;
            rx_wr_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            ack_ph_q  <= ack_ph_d;
            sda_oe_q  <= sda_oe_d;
            rx_data_q <= rx_data_d;
            rw_q      <= rw_d;
            busy_q    <= busy_d;
            tx_rd_q   <= tx_rd_d;
            rx_wr_q   <= rx_wr_d;
            done_q    <= done_d;
        end
    end

    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign tx_rd    = tx_rd_q;
    assign rx_wr    = rx_wr_q;
    assign rx_data  = rx_data_q;
    assign rw       = rw_q;
    assign busy     = busy_q;
    assign i2c_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_i2c_slave
//  Description : Directed bench for i2c_slave acting as the bus initiator.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave;

    localparam int Q = 100;   // quarter SCL period in ns (clk period is 10 ns)

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       scl     = 1'b1;
    logic       m_low   = 1'b0;
    logic [7:0] tx_data = 8'h00;
    wire        sda;
    logic       tx_rd;
    logic [7:0] rx_data;
    logic       rx_wr;
    logic       rw;
    logic       busy;
    logic       i2c_done;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda      (sda),
        .tx_data  (tx_data),
        .tx_rd    (tx_rd),
        .rx_data  (rx_data),
        .rx_wr    (rx_wr),
        .rw       (rw),
        .busy     (busy),
        .i2c_done (i2c_done)
    );

    always #5 clk = ~clk;

    int         n_chk    = 0;
    int         n_pass   = 0;
    int         tx_cnt   = 0;
    int         rx_cnt   = 0;
    int         done_cnt = 0;
    int         both_cnt = 0;
    logic [7:0] rx_last  = 8'h00;
    logic [7:0] rx_prev  = 8'h00;

    // Pulse monitor
    always @(posedge clk) begin
        if (tx_rd)           tx_cnt++;
        if (i2c_done)        done_cnt++;
        if (tx_rd && rx_wr)  both_cnt++;
        if (rx_wr) begin
            rx_prev = rx_last;
            rx_last = rx_data;
            rx_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One SCL period: drv=1 releases SDA, smp is SDA mid-high
    task automatic bus_bit(input logic drv, output logic smp);
        #Q; m_low = ~drv;
        #Q; scl = 1'b1;
        #Q; smp = sda;
        #Q; scl = 1'b0;
    endtask

    task automatic bus_start();
        #Q; m_low = 1'b0;
        #Q; scl = 1'b1;
        #Q; m_low = 1'b1;
        #Q; scl = 1'b0;
    endtask

    task automatic bus_stop();
        #Q; m_low = 1'b1;
        #Q; scl = 1'b1;
        #Q; m_low = 1'b0;
        #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            b[i] = s;
        end
        bus_bit(nack, s);
    endtask

    initial begin
        logic       ack, s, all_hi;
        logic [7:0] rd;
        int         tx0, rx0, dn0;

        // Reset state
        #100;
        check("rst_sda", sda, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rw", rw, 1'b0);
        rst = 1'b1;
        #200;

        // Two-byte write to 0x50
        rx0 = rx_cnt; dn0 = done_cnt;
        bus_start();
        send_byte(8'hA0, ack); check("wr_addr_ack", ack, 1'b0);
        check("wr_busy", busy, 1'b1);
        send_byte(8'hA5, ack); check("wr_d0_ack", ack, 1'b0);
        send_byte(8'h3C, ack); check("wr_d1_ack", ack, 1'b0);
        bus_stop();
        check("wr_rx_cnt", rx_cnt - rx0, 2);
        check("wr_rx0", rx_prev, 8'hA5);
        check("wr_rx1", rx_last, 8'h3C);
        check("wr_rw", rw, 1'b0);
        check("wr_done", done_cnt - dn0, 1);
        check("wr_busy_end", busy, 1'b0);

        // Address 0x51 is not ours
        rx0 = rx_cnt; dn0 = done_cnt; tx0 = tx_cnt;
        bus_start();
        send_byte(8'hA2, ack); check("mis_nack", ack, 1'b1);
        check("mis_busy", busy, 1'b0);
        bus_stop();
        check("mis_pulses", (rx_cnt - rx0) + (tx_cnt - tx0), 0);
        check("mis_done", done_cnt - dn0, 0);

        // Two-byte read: ACK then NACK
        tx0 = tx_cnt;
        tx_data = 8'hC3;
        bus_start();
        send_byte(8'hA1, ack); check("rd_addr_ack", ack, 1'b0);
        #Q; tx_data = 8'h5A;
        check("rd_tx_cnt0", tx_cnt - tx0, 1);
        recv_byte(1'b0, rd); check("rd_byte0", rd, 8'hC3);
        recv_byte(1'b1, rd); check("rd_byte1", rd, 8'h5A);
        check("rd_tx_cnt1", tx_cnt - tx0, 2);
        #Q;
        check("rd_sda_rel", sda, 1'b1);
        check("rd_busy_nack", busy, 1'b0);
        check("rd_rw", rw, 1'b1);
        bus_stop();

        // Write then repeated START into a read
        tx_data = 8'h96;
        bus_start();
        send_byte(8'hA0, ack); check("rs_wr_ack", ack, 1'b0);
        send_byte(8'h11, ack); check("rs_d_ack", ack, 1'b0);
        check("rs_rw0", rw, 1'b0);
        bus_start();
        send_byte(8'hA1, ack); check("rs_rd_ack", ack, 1'b0);
        check("rs_rw1", rw, 1'b1);
        recv_byte(1'b1, rd); check("rs_rd_byte", rd, 8'h96);
        check("rs_rx_data", rx_data, 8'h11);
        bus_stop();

        // Reset while SDA is driven low during the 4th read bit
        tx_data = 8'hE5;
        tx0 = tx_cnt; dn0 = done_cnt;
        bus_start();
        send_byte(8'hA1, ack); check("mr_addr_ack", ack, 1'b0);
        for (int i = 0; i < 3; i++) bus_bit(1'b1, s);
        #Q; m_low = 1'b0;
        #Q; scl = 1'b1;
        #(Q/2);
        check("mr_pre_drive", sda, 1'b0);
        rst = 1'b0;
        #1;
        check("mr_sda_rel", sda, 1'b1);
        check("mr_outs", {tx_rd, rx_wr, i2c_done, rw, busy, rx_data}, 13'h0);
        #(Q/2 - 1); scl = 1'b0;
        #Q; rst = 1'b1;
        all_hi = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_bit(1'b1, s);
            all_hi = all_hi & s;
        end
        check("mr_ignored", all_hi, 1'b1);
        bus_stop();
        check("mr_tx_cnt", tx_cnt - tx0, 1);
        check("mr_done", done_cnt - dn0, 0);

        // STOP after three bits of a write byte, then a normal write
        rx0 = rx_cnt; dn0 = done_cnt;
        bus_start();
        send_byte(8'hA0, ack); check("ab_addr_ack", ack, 1'b0);
        bus_bit(1'b1, s); bus_bit(1'b0, s); bus_bit(1'b1, s);
        bus_stop();
        check("ab_no_rx", rx_cnt - rx0, 0);
        check("ab_done", done_cnt - dn0, 1);
        check("ab_busy", busy, 1'b0);
        bus_start();
        send_byte(8'hA0, ack); check("ab2_addr_ack", ack, 1'b0);
        send_byte(8'h7E, ack); check("ab2_d_ack", ack, 1'b0);
        bus_stop();
        check("ab2_rx_data", rx_data, 8'h7E);
        check("ab2_done", done_cnt - dn0, 2);

        check("no_overlap", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter: SLAVE_ADDR, 7'h50, 7-bit address this responder acknowledges.
REQ-002 SHALL have port: clk  input  1  system clock; SCL/SDA are oversampled, and clk SHALL be >= 8x SCL frequency.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: scl  input  1  I2C clock from initiator (no clock stretching).
REQ-005 SHALL have port: sda  inout  1  I2C data, open-drain: driven 1'b0 or high-Z only, never 1'b1.
REQ-006 SHALL have port: tx_data  input  8  byte to return on read transfers.
REQ-007 SHALL have port: tx_rd  output  1  one-clk pulse when tx_data is captured into the shifter.
REQ-008 SHALL have port: rx_data  output  8  last byte received on write transfers.
REQ-009 SHALL have port: rx_wr  output  1  one-clk pulse when rx_data is updated.
REQ-010 SHALL have port: rw  output  1  R/W bit of the last matched address byte (1 = read).
REQ-011 SHALL have port: busy  output  1  high from address match until STOP, NACKed read, or address mismatch.
REQ-012 SHALL have port: i2c_done  output  1  one-clk pulse on STOP detection following a matched transfer.

Function
REQ-013 SHALL pass scl and sda through 2-flop synchronizers; edge and condition detection SHALL use synchronized values and their one-clk-delayed copies.
REQ-014 SHALL detect START as synchronized sda 1->0 while synchronized scl is high in both current and previous samples; STOP as sda 0->1 under the same scl condition.
REQ-015 SHALL sample SDA on synchronized SCL rising edges and change its SDA drive only on synchronized SCL falling edges.
REQ-016 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK using a 3-bit bit counter; bytes are MSB first.
REQ-017 SHALL move from any state to ADDR, clear the bit counter, and release SDA on START, including a repeated START.
REQ-018 SHALL move from any state to IDLE and release SDA on STOP; i2c_done SHALL pulse only if busy was high.
REQ-019 SHALL, on the 8th ADDR rising edge, compare bits [7:1] to SLAVE_ADDR: on match, latch rw, set busy, and go to ADDR_ACK; on mismatch, go to IDLE and never drive SDA until the next START.
REQ-020 SHALL drive SDA low from the SCL falling edge after the 8th bit through the following SCL falling edge (ACK bit time) in ADDR_ACK and WR_ACK.
REQ-021 SHALL, in WR_DATA, after 8 bits update rx_data and pulse rx_wr within 1 clk of the 8th rising edge, then go to WR_ACK and on to WR_DATA; every data byte is ACKed.
REQ-022 SHALL, for a read, capture tx_data and pulse tx_rd on the SCL falling edge ending ADDR_ACK, then drive the MSB.
REQ-023 SHALL, in RD_DATA, drive bit value 0 as low and 1 as released; it SHALL release SDA on the falling edge after the 8th bit (RD_ACK).
REQ-024 SHALL, in RD_ACK, sample the initiator's bit on the rising edge: low (ACK) reloads tx_data with a tx_rd pulse at the next falling edge; high (NACK) goes to IDLE, clears busy, and keeps SDA released.
REQ-025 SHALL produce tx_rd and rx_wr as exactly one-clk pulses, never simultaneously asserted.

Reset
REQ-026 SHALL, on rst low, release SDA immediately (asynchronously), clear rx_data, rw, busy, tx_rd, rx_wr, i2c_done, and the bit counter to 0, and enter IDLE; synchronizer flops SHALL reset to 1.
REQ-027 SHALL, after rst deasserts mid-transfer, ignore bus activity until the next START.

Verification
REQ-028 SHALL pass: START, 0xA0, 0xA5, 0x3C, STOP -> three ACKs, rx_wr pulses with rx_data 0xA5 then 0x3C, rw=0, one i2c_done pulse.
REQ-029 SHALL pass: START, 0xA2 (address 0x51) -> SDA high at the 9th bit, no pulses, busy stays 0, and no i2c_done on STOP.
REQ-030 SHALL pass: START, 0xA1 with tx_data 0xC3 then 0x5A, initiator ACK then NACK, STOP -> SDA bits 11000011 then 01011010, two tx_rd pulses, SDA released after the NACK.
REQ-031 SHALL pass: write 0x11 to 0xA0, repeated START, read 0xA1 -> rx_data=0x11, rw changes to 1, read data correct.
REQ-032 SHALL pass: rst asserted during the 4th bit of a read byte with SDA driven low -> SDA high-Z within the same clk and all outputs 0.
REQ-033 SHALL pass: STOP injected after 3 bits of a write byte -> IDLE, no rx_wr, i2c_done pulse, and the next transfer succeeds.
